// File: rtl/hub75_row_driver.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_row_driver (with hub75_pkg row types)
//  Description : Accepts one RGB row per handshake and drives the HUB75 panel:
//                serial shift, blank, address update, latch and lit period.
//  Revision    : 1.0 - initial release
// ============================================================================

package hub75_pkg;
    localparam int GL_NUM_COL_PIXELS = 32;

    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_half_t;

    typedef struct packed {
        rgb_half_t top;
        rgb_half_t bot;
    } rgb_row_t;

    localparam int GL_RGB_ROW_W = $bits(rgb_row_t);
endpackage

module hub75_row_driver
    import hub75_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int BLANK_CYCLES  = 4,
    parameter int LATCH_CYCLES  = 2,
    parameter int MIN_ON_CYCLES = 64
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  rgb_row_t   row_in,
    input  logic [3:0] row_address_in,
    input  logic       row_valid_in,
    output logic       row_ready_out,
    output logic       r1_out,
    output logic       g1_out,
    output logic       b1_out,
    output logic       r2_out,
    output logic       g2_out,
    output logic       b2_out,
    output logic       panel_clk_out,
    output logic       lat_out,
    output logic       oe_n_out,
    output logic [3:0] addr_out
);

    localparam int c_N       = GL_NUM_COL_PIXELS;
    localparam int c_BIT_W   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_MAX_BL  = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int c_SEQ_MAX = (c_MAX_BL > MIN_ON_CYCLES) ? c_MAX_BL : MIN_ON_CYCLES;
    localparam int c_SEQ_W   = $clog2(c_SEQ_MAX + 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SHIFT = 3'd1;
    localparam logic [2:0] c_BLANK = 3'd2;
    localparam logic [2:0] c_LATCH = 3'd3;
    localparam logic [2:0] c_ON    = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_DIV_W-1:0] r_div;
    logic               r_phase;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_SEQ_W-1:0] r_seq;
    rgb_row_t           r_row;
    logic [3:0]         r_addr_next;
    logic               r_shown;

    logic               r_ready;
    logic               r_pclk;
    logic               r_lat;
    logic               r_oe_n;
    logic [3:0]         r_addr;
    logic [5:0]         r_rgb;

    logic               w_ready;
    logic               w_pclk;
    logic               w_lat;
    logic               w_oe_n;
    logic [3:0]         w_addr;
    logic [5:0]         w_rgb;

    logic               w_handshake;
    logic               w_div_last;
    logic               w_shift_done;
    logic               w_seq_last;

    assign w_handshake  = row_valid_in & r_ready;
    assign w_div_last   = (r_div == c_DIV_W'(CLK_DIV - 1));
    assign w_shift_done = r_phase & w_div_last & (r_bit == '0);

    always_comb begin
        w_seq_last = 1'b0;
        case (r_state)
            c_BLANK: w_seq_last = (r_seq == c_SEQ_W'(BLANK_CYCLES - 1));
            c_LATCH: w_seq_last = (r_seq == c_SEQ_W'(LATCH_CYCLES - 1));
            c_ON:    w_seq_last = (r_seq == c_SEQ_W'(MIN_ON_CYCLES - 1));
            default: w_seq_last = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_handshake)  w_state_next = c_SHIFT;
            c_SHIFT: if (w_shift_done) w_state_next = c_BLANK;
            c_BLANK: if (w_seq_last)   w_state_next = c_LATCH;
            c_LATCH: if (w_seq_last)   w_state_next = c_ON;
            c_ON:    if (w_seq_last)   w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Shift counters, phase sequencer, shadow registers and lit flag
    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_div       <= '0;
            r_phase     <= 1'b0;
            r_bit       <= '0;
            r_seq       <= '0;
            r_row       <= '0;
            r_addr_next <= '0;
            r_shown     <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_row       <= row_in;
                r_addr_next <= row_address_in;
                r_div       <= '0;
                r_phase     <= 1'b0;
                r_bit       <= c_BIT_W'(c_N - 1);
            end else if (r_state == c_SHIFT) begin
                if (w_div_last) begin
                    r_div   <= '0;
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_bit <= r_bit - 1'b1;
                    end
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            if (w_state_next != r_state) begin
                r_seq <= '0;
            end else if ((r_state == c_BLANK) || (r_state == c_LATCH) || (r_state == c_ON)) begin
                r_seq <= r_seq + 1'b1;
            end

            if ((r_state == c_LATCH) && (w_state_next == c_ON)) begin
                r_shown <= 1'b1;
            end
        end
    end

    // Output decode; every pin is registered one cycle behind the state
    always_comb begin
        w_ready = 1'b0;
        w_pclk  = 1'b0;
        w_lat   = 1'b0;
        w_oe_n  = 1'b1;
        w_addr  = r_addr;
        w_rgb   = r_rgb;
        case (r_state)
            c_IDLE: begin
                w_ready = ~w_handshake;
                w_oe_n  = ~r_shown;
            end
            c_SHIFT: begin
                w_oe_n = ~r_shown;
                w_pclk = r_phase;
                if (!r_phase && (r_div == '0)) begin
                    w_rgb = {r_row.top.red[r_bit], r_row.top.green[r_bit], r_row.top.blue[r_bit],
                             r_row.bot.red[r_bit], r_row.bot.green[r_bit], r_row.bot.blue[r_bit]};
                end
            end
            c_BLANK: begin
                // The panel is dark from this cycle on, so the address may move
                if (r_seq == '0) begin
                    w_addr = r_addr_next;
                end
            end
            c_LATCH: begin
                w_lat = 1'b1;
            end
            c_ON: begin
                w_oe_n = 1'b0;
            end
            default: begin
                w_oe_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            r_ready <= 1'b0;
            r_pclk  <= 1'b0;
            r_lat   <= 1'b0;
            r_oe_n  <= 1'b1;
            r_addr  <= '0;
            r_rgb   <= '0;
        end else begin
            r_ready <= w_ready;
            r_pclk  <= w_pclk;
            r_lat   <= w_lat;
            r_oe_n  <= w_oe_n;
            r_addr  <= w_addr;
            r_rgb   <= w_rgb;
        end
    end

    assign row_ready_out = r_ready;
    assign panel_clk_out = r_pclk;
    assign lat_out       = r_lat;
    assign oe_n_out      = r_oe_n;
    assign addr_out      = r_addr;
    assign r1_out        = r_rgb[5];
    assign g1_out        = r_rgb[4];
    assign b1_out        = r_rgb[3];
    assign r2_out        = r_rgb[2];
    assign g2_out        = r_rgb[1];
    assign b2_out        = r_rgb[0];

endmodule

`default_nettype wire

// File: doc/hub75_row_driver.md
Name: hub75_row_driver

Overview:
Consumer end of the pattern-generator row interface. Accepts one `rgb_row_t` row plus a 4-bit row address per valid/ready handshake. Serialises the row onto the HUB75 panel pins (R1/G1/B1 for the top half, R2/G2/B2 for the bottom half), then sequences blank, address update, latch and unblank. Sits between the pattern generators and the panel connector.

Parameters:
CLK_DIV, 2, system cycles per panel_clk phase (low phase and high phase each); must be >= 1
BLANK_CYCLES, 4, cycles oe_n_out is held high before the latch pulse; must be >= 1
LATCH_CYCLES, 2, width of the lat_out pulse in cycles; must be >= 1
MIN_ON_CYCLES, 64, minimum cycles oe_n_out is held low after a latch before the next row is accepted; must be >= 1

Ports:
clk_in  in  1  system clock
n_reset_in  in  1  asynchronous active-low reset
row_in  in  GL_RGB_ROW_W  rgb_row_t row data; .top/.bot each carry .red/.green/.blue, GL_NUM_COL_PIXELS (N) bits each
row_address_in  in  4  panel row address for row_in
row_valid_in  in  1  row_in/row_address_in valid
row_ready_out  out  1  driver can accept a row
r1_out, g1_out, b1_out  out  1 each  top-half serial colour data
r2_out, g2_out, b2_out  out  1 each  bottom-half serial colour data
panel_clk_out  out  1  panel shift clock
lat_out  out  1  panel latch, active high
oe_n_out  out  1  panel output enable, active low
addr_out  out  4  panel row address A..D

Behaviour:
- Clock and reset: one clock, `clk_in`; reset `n_reset_in` is asynchronous, active-low. All outputs are registered.
- Reset values:
  - row_ready_out=0, panel_clk_out=0, lat_out=0, oe_n_out=1, addr_out=0, all colour outputs=0.
  - FSM in IDLE; internal flag `shown`=0.
  - row_ready_out rises on the first clock edge after reset release.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. The partially shifted row is discarded.
- FSM states: IDLE -> SHIFT -> BLANK -> LATCH -> ON -> IDLE.
- IDLE:
  - row_ready_out=1.
  - A handshake occurs on a clock edge where row_valid_in=1 and row_ready_out=1. On that edge, row_in and row_address_in are captured into shadow registers, row_ready_out drops to 0 and the FSM enters SHIFT.
  - row_in changes while not ready are ignored. row_valid_in held high without ready waits; there is no loss.
- SHIFT:
  - Exactly N bits, column index N-1 first, down to column 0.
  - Each bit occupies 2*CLK_DIV cycles: panel_clk_out=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - Colour outputs update only on the first low-phase cycle of each bit and hold stable through the high phase. r1/g1/b1 come from .top.red/.green/.blue[col]; r2/g2/b2 come from .bot.
  - After the last high phase, panel_clk_out returns to 0 and the FSM enters BLANK.
  - SHIFT lasts 2*CLK_DIV*N cycles. Bit/column counter width is $clog2(N).
- oe_n_out during IDLE and SHIFT: 0 if shown=1 (previous row stays lit while the next row shifts), otherwise 1.
- BLANK:
  - oe_n_out=1 for BLANK_CYCLES cycles.
  - addr_out loads the captured address on the first BLANK cycle, never while oe_n_out=0.
- LATCH:
  - lat_out=1 and oe_n_out=1 for LATCH_CYCLES cycles.
  - lat_out returns to 0 on ON entry; shown is set to 1.
- ON:
  - oe_n_out=0 for MIN_ON_CYCLES cycles, then IDLE.
  - row_ready_out is reasserted on the IDLE entry edge.
- Throughput: accept-to-ready = 1 + 2*CLK_DIV*N + BLANK_CYCLES + LATCH_CYCLES + MIN_ON_CYCLES cycles.
- Colour outputs hold their last shifted value outside SHIFT. panel_clk_out and lat_out are never high at the same time.
- Address wrap: any value 0..15 is accepted. Repeated addresses are legal and re-latched.

Test Plan:
1. Reset, then release with row_valid_in=0 -> one cycle later row_ready_out=1; oe_n_out=1, lat_out=0, panel_clk_out=0, addr_out=0 held indefinitely.
2. CLK_DIV=2; send row with .top.red=all 1, all else 0, address 5 -> exactly N panel_clk_out rising edges, each 2 cycles low / 2 high; r1_out=1 and all other colours 0 at every rising edge; addr_out=5 only while oe_n_out=1; then lat_out=1 for 2 cycles; then oe_n_out=0 for 64 cycles; ready reasserts 4N+71 cycles after acceptance.
3. Walking-one pattern: .bot.green bit 0 only set -> g2_out=1 only at the Nth (last) rising edge; checks MSB-first ordering and that data is stable across each high phase.
4. Hold row_valid_in=1 continuously with addresses 0,1,...,15,0 -> every row is accepted exactly once, in order. oe_n_out stays 0 through each SHIFT after the first latch. addr_out never changes while oe_n_out=0. Address wraps 15->0 correctly.
5. Change row_in every cycle during SHIFT -> shifted bits match the value captured at the handshake only.
6. Assert n_reset_in low midway through SHIFT -> outputs go to reset values without waiting for a clock edge. After release, the next row shifts fully from column N-1 and oe_n_out stays 1 until that row is latched (shown=0).
